// File: rtl/osd_him_egress_arb.sv
// Packet-level round-robin arbiter that shares the host-interface egress DII port between NUM_PORTS sources.
// Optional build macro OSD_HIM_ARB_PRIO_EN gives port 0 strict priority over the round-robin ports.
module osd_him_egress_arb #(
    parameter int unsigned  NUM_PORTS = 4,
    localparam int unsigned IDW       = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [16*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]    in_valid,
    input  logic [NUM_PORTS-1:0]    in_last,
    output logic [NUM_PORTS-1:0]    in_ready,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy
);

`ifdef OSD_HIM_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_PASS} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic [IDW:0]   idx_w;
    logic           found;
    logic           sel_valid;
    logic           sel_last;
    logic [15:0]    sel_data;
    logic           pkt_done;

    // Mux of the currently granted source.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[16*i +: 16];
            end
        end
    end

    // Winner search: nearest requester at or after rr_q, wrapping; port 0 first when prioritised.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx_w = '0;
        idx   = '0;
        if (PRIO_EN && in_valid[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_w = {1'b0, rr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NUM_PORTS)) begin
                idx_w = idx_w - (IDW+1)'(NUM_PORTS);
            end
            idx = idx_w[IDW-1:0];
            if (!found && in_valid[idx] && !(PRIO_EN && (idx == '0))) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Combinational pass-through while a packet owns the port.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        if (state_q == ST_PASS) begin
            out_valid = sel_valid;
            out_last  = sel_last;
            out_data  = sel_data;
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_ready[i] = (grant_q == IDW'(i)) && out_ready;
            end
        end
    end

    assign pkt_done = (state_q == ST_PASS) && sel_valid && out_ready && sel_last;
    assign rr_next  = (grant_q == IDW'(NUM_PORTS-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (pkt_done) begin
                    state_d = ST_IDLE;
                    // A prioritised port-0 packet leaves the rotation untouched.
                    if (!(PRIO_EN && (grant_q == '0))) begin
                        rr_d = rr_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ST_PASS);

endmodule

// File: tb/tb_osd_him_egress_arb.sv
// Bench for osd_him_egress_arb: packet-level reference model checked every cycle, plus literal flit-log checks.
module tb_osd_him_egress_arb;
    localparam int unsigned N = 4;
`ifdef OSD_HIM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [16*N-1:0] in_data;
    logic [N-1:0]    in_valid, in_last, in_ready;
    logic [15:0]     out_data;
    logic            out_valid, out_last, out_ready;
    logic [1:0]      grant_id;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [16:0] srcq [N][$];
    logic [N-1:0] acc;
    logic         rdy_toggle;

    int          log_g[$];
    logic [15:0] log_d[$];
    logic        log_l[$];

    int  m_busy, m_gnt, m_rr;
    int  n_busy, n_gnt, n_rr;

    always #5 clk = ~clk;

    osd_him_egress_arb #(.NUM_PORTS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one owner per packet, rotating pointer advanced after each completed packet.
    always @(negedge clk) begin
        logic [15:0] e_data;
        logic        e_valid, e_last;
        logic [N-1:0] e_rdy;
        int w;
        e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_rdy = '0;
        if (m_busy != 0) begin
            e_valid = in_valid[m_gnt];
            e_last  = in_last[m_gnt];
            e_data  = in_data[16*m_gnt +: 16];
            e_rdy[m_gnt] = out_ready;
        end
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("out_last",  32'(out_last),  32'(e_last));
        check("out_data",  32'(out_data),  32'(e_data));
        check("in_ready",  32'(in_ready),  32'(e_rdy));
        check("busy",      32'(busy),      32'(m_busy));
        check("grant_id",  32'(grant_id),  32'(m_gnt));

        n_busy = m_busy; n_gnt = m_gnt; n_rr = m_rr;
        if (m_busy == 0) begin
            w = -1;
            if (PRIO && in_valid[0]) w = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_rr + k) % N;
                if (w < 0 && in_valid[p] && !(PRIO && p == 0)) w = p;
            end
            if (w >= 0) begin
                n_busy = 1; n_gnt = w;
            end
        end else if (in_valid[m_gnt] && out_ready && in_last[m_gnt]) begin
            n_busy = 0;
            if (!(PRIO && m_gnt == 0)) n_rr = (m_gnt + 1) % N;
        end

        if (out_valid && out_ready) begin
            log_g.push_back(int'(grant_id));
            log_d.push_back(out_data);
            log_l.push_back(out_last);
        end
        acc = in_valid & in_ready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_gnt <= 0; m_rr <= 0;
        end else begin
            m_busy <= n_busy; m_gnt <= n_gnt; m_rr <= n_rr;
        end
    end

    task automatic push(input int p, input logic [15:0] d, input logic l);
        srcq[p].push_back({l, d});
    endtask

    // One clock: retire accepted flits, then present each source's head flit.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_last[i]  = srcq[i][0][16];
                in_data[16*i +: 16] = srcq[i][0][15:0];
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'b0;
                in_data[16*i +: 16] = '0;
            end
        end
        out_ready = rdy_toggle ? ~out_ready : 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (m_busy == 0) && (srcq[0].size() == 0) && (srcq[1].size() == 0)
                && (srcq[2].size() == 0) && (srcq[3].size() == 0);
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic chk_flit(input string nm, input int i, input int g, input logic [15:0] d, input logic l);
        if (i >= log_g.size()) begin
            check({nm, "_present"}, 32'd0, 32'd1);
        end else begin
            check({nm, "_grant"}, 32'(log_g[i]), 32'(g));
            check({nm, "_data"},  32'(log_d[i]), 32'(d));
            check({nm, "_last"},  32'(log_l[i]), 32'(l));
        end
    endtask

    initial begin
        int base, n, k;
        int ord[$];
        int exp_ord[5];
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1; rdy_toggle = 1'b0;

        // Reset with every port requesting.
        for (int p = 0; p < N; p++) begin
            push(p, 16'(16'h0A00 + p), 1'b0);
            push(p, 16'(16'h0B00 + p), 1'b1);
        end
        push(0, 16'h0C00, 1'b0);
        push(0, 16'h0D00, 1'b1);
        step(); step();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant",     32'(grant_id),  32'd0);
        rst_n = 1'b1;

        // All ports contending with 2-flit packets.
        drain(200);
        check("rr_flits", 32'(log_g.size()), 32'd10);
        for (int i = 0; i < log_g.size(); i++) if (log_l[i]) ord.push_back(log_g[i]);
        if (PRIO) exp_ord = '{0, 0, 1, 2, 3};
        else      exp_ord = '{0, 1, 2, 3, 0};
        check("rr_pkts", 32'(ord.size()), 32'd5);
        for (int i = 0; i < 5 && i < ord.size(); i++) check("rr_order", 32'(ord[i]), 32'(exp_ord[i]));
        chk_flit("rr_first", 0, 0, 16'h0A00, 1'b0);
        chk_flit("rr_second", 1, 0, 16'h0B00, 1'b1);

        // Port 2 alone, 3-flit packet.
        base = log_g.size();
        push(2, 16'h0003, 1'b0);
        push(2, 16'hAAAA, 1'b0);
        push(2, 16'hBBBB, 1'b1);
        drain(50);
        chk_flit("p2_f0", base,     2, 16'h0003, 1'b0);
        chk_flit("p2_f1", base + 1, 2, 16'hAAAA, 1'b0);
        chk_flit("p2_f2", base + 2, 2, 16'hBBBB, 1'b1);

        // Ports 0 and 3 together: pointer now sits at 3.
        base = log_g.size();
        push(0, 16'h00C0, 1'b1);
        push(3, 16'h00C3, 1'b1);
        drain(50);
        if (PRIO) begin
            chk_flit("ptr_a", base,     0, 16'h00C0, 1'b1);
            chk_flit("ptr_b", base + 1, 3, 16'h00C3, 1'b1);
        end else begin
            chk_flit("ptr_a", base,     3, 16'h00C3, 1'b1);
            chk_flit("ptr_b", base + 1, 0, 16'h00C0, 1'b1);
        end

        // Port 1 with out_ready toggling every cycle.
        base = log_g.size();
        for (int i = 0; i < 4; i++) push(1, 16'(16'h1101 + i), i == 3);
        rdy_toggle = 1'b1;
        drain(80);
        rdy_toggle = 1'b0;
        check("stall_flits", 32'(log_g.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) chk_flit("stall", base + i, 1, 16'(16'h1101 + i), i == 3);

        // Reset in the middle of a port-3 packet while port 0 is pending.
        base = log_g.size();
        for (int i = 0; i < 4; i++) push(3, 16'(16'h3301 + i), i == 3);
        n = 0;
        while (log_g.size() < base + 1 && n < 50) begin step(); n++; end
        check("mid_wait", 32'(log_g.size() >= base + 1), 32'd1);
        push(0, 16'h0050, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_grant",     32'(grant_id),  32'd0);
        check("midrst_flits", 32'(log_g.size() - base), 32'd2);
        step(); step();
        rst_n = 1'b1;
        base = log_g.size();
        drain(80);
        chk_flit("post_rst0", base,     0, 16'h0050, 1'b1);
        chk_flit("post_rst1", base + 1, 3, 16'h3303, 1'b0);
        chk_flit("post_rst2", base + 2, 3, 16'h3304, 1'b1);

        if (PRIO) begin
            // Port 0 with two packets against ports 1-3.
            base = log_g.size();
            push(0, 16'h0E00, 1'b1);
            push(0, 16'h0E01, 1'b1);
            for (int p = 1; p < N; p++) push(p, 16'(16'h0F00 + p), 1'b1);
            drain(80);
            check("prio_flits", 32'(log_g.size() - base), 32'd5);
            if (log_g.size() >= base + 5) begin
                check("prio_w0", 32'(log_g[base]),     32'd0);
                check("prio_w1", 32'(log_g[base + 1]), 32'd0);
                for (k = 2; k < 4; k++)
                    check("prio_rot", 32'(log_g[base + k + 1]), 32'((log_g[base + k] % 3) + 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
